// File: rtl/aes_tseq_pkg.sv
// Shared definitions for the AES LFSR test sequencer: LFSR tap masks, zero-seed
// substitutes, FSM state encoding and the common LFSR/MISR step function.
package aes_tseq_pkg;

  localparam int unsigned LFSR_MAX_W = 256;

  // Maximal-length trinomial-free polynomials, e.g. x^128 + x^126 + x^101 + x^99 + 1
  localparam logic [LFSR_MAX_W-1:0] TAPS_128 =
    (256'd1 << 127) | (256'd1 << 125) | (256'd1 << 100) | (256'd1 << 98);
  localparam logic [LFSR_MAX_W-1:0] TAPS_192 =
    (256'd1 << 191) | (256'd1 << 189) | (256'd1 << 177) | (256'd1 << 176);
  localparam logic [LFSR_MAX_W-1:0] TAPS_256 =
    (256'd1 << 255) | (256'd1 << 253) | (256'd1 << 250) | (256'd1 << 245);

  localparam logic [127:0] ZERO_SUB_DATA = 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;
  localparam logic [255:0] ZERO_SUB_KEY  =
    256'hCAFE_FEED_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } tseq_state_e;

  function automatic logic [LFSR_MAX_W-1:0] tap_mask(input int unsigned w);
    case (w)
      192:     return TAPS_192;
      256:     return TAPS_256;
      default: return TAPS_128;
    endcase
  endfunction

  // Operates on a zero-extended value; result is masked back to w bits.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] cur,
                                                      input int unsigned w);
    logic                  fb;
    logic [LFSR_MAX_W-1:0] mask;
    fb   = ^(cur & tap_mask(w));
    mask = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - w);
    return {cur[LFSR_MAX_W-2:0], fb} & mask;
  endfunction

endpackage

// File: rtl/tseq_lfsr.sv
// W-bit Fibonacci LFSR with seed load; an all-zero seed is replaced by ZERO_SUB
// so the register can never lock up.
module tseq_lfsr
  import aes_tseq_pkg::*;
#(
  parameter int unsigned           W        = 128,
  parameter logic [LFSR_MAX_W-1:0] ZERO_SUB = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == '0) ? W'(ZERO_SUB) : seed;
    end else if (step) begin
      q_d = W'(lfsr_next(LFSR_MAX_W'(q_q), W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/aes_lfsr_test_seq.sv
// Stimulus/check sequencer for a fixed-latency pipelined AES core: issues LFSR
// plaintext/key vectors, retires ciphertexts LATENCY cycles later into a MISR.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   SEED  | one cycle: clear counters and signature
//   RUN   | issue one vector per cycle unless hold
//   DRAIN | all vectors issued, waiting for the last ciphertext
//   DONE  | signature final; waiting for the next start
module aes_lfsr_test_seq
  import aes_tseq_pkg::*;
#(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned KEY_W   = 128,
  parameter int unsigned LATENCY = 21,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_tests,
  input  logic [DATA_W-1:0] state_seed,
  input  logic [KEY_W-1:0]  key_seed,
  input  logic              hold,
  input  logic [DATA_W-1:0] aes_ct,
  output logic [DATA_W-1:0] aes_state,
  output logic [KEY_W-1:0]  aes_key,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [DATA_W-1:0] signature
);

  tseq_state_e       state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [DATA_W-1:0] sig_q, sig_d;
  logic [DATA_W-1:0] aes_state_q, aes_state_d;
  logic [KEY_W-1:0]  aes_key_q, aes_key_d;
  logic [LATENCY-1:0] vpipe_q, vpipe_d;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] pt_lfsr;
  logic [KEY_W-1:0]  key_lfsr;
  logic              start_ok, issue, retire;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign issue    = (state_q == RUN) && !hold;
  assign retire   = vpipe_q[LATENCY-1];

  // Seeds go straight into the LFSRs when start is accepted, so the SEED
  // cycle needs no separate seed holding registers.
  tseq_lfsr #(
    .W        (DATA_W),
    .ZERO_SUB (LFSR_MAX_W'(ZERO_SUB_DATA))
  ) u_pt_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .seed  (state_seed),
    .step  (issue),
    .q     (pt_lfsr)
  );

  tseq_lfsr #(
    .W        (KEY_W),
    .ZERO_SUB (ZERO_SUB_KEY)
  ) u_key_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .seed  (key_seed),
    .step  (issue),
    .q     (key_lfsr)
  );

  always_comb begin
    num_d       = start_ok ? num_tests : num_q;
    issued_d    = issued_q;
    retired_d   = retired_q;
    sig_d       = sig_q;
    aes_state_d = aes_state_q;
    aes_key_d   = aes_key_q;
    vpipe_d     = (vpipe_q << 1) | LATENCY'(issue);
    if (state_q == SEED) begin
      issued_d  = '0;
      retired_d = '0;
      sig_d     = '0;
    end else begin
      if (issue) begin
        aes_state_d = pt_lfsr;
        aes_key_d   = key_lfsr;
        issued_d    = issued_q + CNT_W'(1);
      end
      if (retire) begin
        sig_d     = DATA_W'(lfsr_next(LFSR_MAX_W'(sig_q), DATA_W)) ^ aes_ct;
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_ok) state_d = SEED;
      SEED:       state_d = (num_q == '0) ? DONE : RUN;
      RUN:        if (issue && (issued_d == num_q)) state_d = DRAIN;
      DRAIN:      if (retired_q == num_q) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      num_q       <= '0;
      issued_q    <= '0;
      retired_q   <= '0;
      sig_q       <= '0;
      aes_state_q <= '0;
      aes_key_q   <= '0;
      vpipe_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      retired_q   <= retired_d;
      sig_q       <= sig_d;
      aes_state_q <= aes_state_d;
      aes_key_q   <= aes_key_d;
      vpipe_q     <= vpipe_d;
      busy_q      <= state_d inside {SEED, RUN, DRAIN};
      done_q      <= (state_d == DONE);
    end
  end

  assign aes_state   = aes_state_q;
  assign aes_key     = aes_key_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign issued_cnt  = issued_q;
  assign retired_cnt = retired_q;
  assign signature   = sig_q;

endmodule

// File: tb/tb_aes_lfsr_test_seq.sv
// Scoreboard bench for aes_lfsr_test_seq: two instances (128-bit key/LATENCY 21
// and 256-bit key/LATENCY 29), each core modelled as a LATENCY-deep delay line.
module tb_aes_lfsr_test_seq;

  localparam int LAT1 = 21;
  localparam int LAT2 = 29;
  localparam logic [127:0] ZSD = 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;
  localparam logic [255:0] ZSK =
    256'hCAFE_FEED_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         start1, hold1, busy1, done1;
  logic [31:0]  num1, iss1, ret1;
  logic [127:0] sseed1, kseed1, ct1, st1, key1, sig1;

  logic         start2, hold2, busy2, done2;
  logic [31:0]  num2, iss2, ret2;
  logic [127:0] sseed2, ct2, st2, sig2;
  logic [255:0] kseed2, key2;

  aes_lfsr_test_seq #(.DATA_W(128), .KEY_W(128), .LATENCY(LAT1), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .num_tests(num1), .state_seed(sseed1),
    .key_seed(kseed1), .hold(hold1), .aes_ct(ct1), .aes_state(st1), .aes_key(key1),
    .busy(busy1), .done(done1), .issued_cnt(iss1), .retired_cnt(ret1), .signature(sig1));

  aes_lfsr_test_seq #(.DATA_W(128), .KEY_W(256), .LATENCY(LAT2), .CNT_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .num_tests(num2), .state_seed(sseed2),
    .key_seed(kseed2), .hold(hold2), .aes_ct(ct2), .aes_state(st2), .aes_key(key2),
    .busy(busy2), .done(done2), .issued_cnt(iss2), .retired_cnt(ret2), .signature(sig2));

  // Core models: ct seen on the sampling edge equals aes_state presented LAT cycles earlier
  logic [127:0] dl1 [LAT1-1];
  logic [127:0] dl2 [LAT2-1];
  always @(posedge clk) begin
    dl1[0] <= st1;
    for (int k = LAT1 - 2; k > 0; k--) dl1[k] <= dl1[k-1];
    dl2[0] <= st2;
    for (int k = LAT2 - 2; k > 0; k--) dl2[k] <= dl2[k-1];
  end
  assign ct1 = dl1[LAT1-2];
  assign ct2 = dl2[LAT2-2];

  typedef struct {
    logic [31:0]  iss;
    logic [31:0]  ret;
    logic [127:0] sig;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] m_step(input logic [255:0] c, input int w);
    int t0, t1, t2, t3;
    logic [255:0] r;
    case (w)
      192:     begin t0 = 191; t1 = 189; t2 = 177; t3 = 176; end
      256:     begin t0 = 255; t1 = 253; t2 = 250; t3 = 245; end
      default: begin t0 = 127; t1 = 125; t2 = 100; t3 = 98;  end
    endcase
    r    = c << 1;
    r[0] = c[t0] ^ c[t1] ^ c[t2] ^ c[t3];
    for (int i = 0; i < 256; i++) if (i >= w) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic [127:0] model_sig(input logic [127:0] seed, input int n);
    logic [127:0] v, s;
    logic [255:0] tmp;
    v = (seed == '0) ? ZSD : seed;
    s = '0;
    for (int i = 0; i < n; i++) begin
      tmp = m_step({128'b0, s}, 128);
      s   = tmp[127:0] ^ v;
      tmp = m_step({128'b0, v}, 128);
      v   = tmp[127:0];
    end
    return s;
  endfunction

  function automatic exp_t mk(input int iss, input int ret, input logic [127:0] sig);
    exp_t e;
    e.iss = iss;
    e.ret = ret;
    e.sig = sig;
    return e;
  endfunction

  // Monitor: every rising done pops one expected run result
  logic d1p = 1'b0;
  logic d2p = 1'b0;
  always @(negedge clk) begin
    if (done1 && !d1p) begin
      if (q1.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL dut1 unexpected done: no run result expected");
      end else begin
        e1 = q1.pop_front();
        chk("dut1 issued_cnt", {224'b0, iss1}, {224'b0, e1.iss});
        chk("dut1 retired_cnt", {224'b0, ret1}, {224'b0, e1.ret});
        chk("dut1 signature", {128'b0, sig1}, {128'b0, e1.sig});
      end
    end
    if (done2 && !d2p) begin
      if (q2.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL dut2 unexpected done: no run result expected");
      end else begin
        e2 = q2.pop_front();
        chk("dut2 issued_cnt", {224'b0, iss2}, {224'b0, e2.iss});
        chk("dut2 retired_cnt", {224'b0, ret2}, {224'b0, e2.ret});
        chk("dut2 signature", {128'b0, sig2}, {128'b0, e2.sig});
      end
    end
    d1p = done1;
    d2p = done2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int sel, input int budget);
    int i;
    i = 0;
    while (((sel == 1) ? done1 : done2) !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    n_checks++;
    if (((sel == 1) ? done1 : done2) !== 1'b1) begin
      n_errors++;
      $display("FAIL wait_done dut%0d: done still low after %0d cycles", sel, budget);
    end
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, " aes_state"}, {128'b0, st1}, 256'd0);
    chk({tag, " aes_key"}, {128'b0, key1}, 256'd0);
    chk({tag, " busy"}, {255'b0, busy1}, 256'd0);
    chk({tag, " done"}, {255'b0, done1}, 256'd0);
    chk({tag, " issued"}, {224'b0, iss1}, 256'd0);
    chk({tag, " retired"}, {224'b0, ret1}, 256'd0);
    chk({tag, " signature"}, {128'b0, sig1}, 256'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] S5 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] K5 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] S3 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

  initial begin
    rst_n = 1'b0;
    start1 = 0; hold1 = 0; num1 = 0; sseed1 = 0; kseed1 = 0;
    start2 = 0; hold2 = 0; num2 = 0; sseed2 = 0; kseed2 = 0;
    repeat (3) tick();
    chk_zero1("reset");
    rst_n = 1'b1;
    tick();

    // num_tests = 0: done two cycles after start, empty signature
    num1 = 0;
    q1.push_back(mk(0, 0, 128'h0));
    start1 = 1; tick(); start1 = 0;
    chk("zero_n done +1", {255'b0, done1}, 256'd0);
    chk("zero_n busy +1", {255'b0, busy1}, 256'd1);
    tick();
    chk("zero_n done +2", {255'b0, done1}, 256'd1);
    wait_done(1, 5);
    tick();

    // num_tests = 1, seed 1: single retire exactly LATENCY after issue
    num1 = 1; sseed1 = 128'h1; kseed1 = 128'h0F0F;
    q1.push_back(mk(1, 1, 128'h1));
    start1 = 1; tick(); start1 = 0;
    tick(); tick();
    chk("one aes_state", {128'b0, st1}, 256'h1);
    chk("one aes_key", {128'b0, key1}, 256'h0F0F);
    chk("one issued", {224'b0, iss1}, 256'd1);
    repeat (LAT1 - 1) tick();
    chk("one retire early", {224'b0, ret1}, 256'd0);
    tick();
    chk("one retire on time", {224'b0, ret1}, 256'd1);
    wait_done(1, 10);
    tick();

    // num_tests = 5 with hold on RUN cycles 2-3 and an ignored start mid-RUN
    num1 = 5; sseed1 = S5; kseed1 = K5;
    q1.push_back(mk(5, 5, model_sig(S5, 5)));
    start1 = 1; tick(); start1 = 0;
    tick(); tick();
    chk("hold first aes_state", {128'b0, st1}, {128'b0, S5});
    chk("hold first aes_key", {128'b0, key1}, {128'b0, K5});
    hold1 = 1; tick(); tick();
    chk("hold issued frozen", {224'b0, iss1}, 256'd1);
    chk("hold aes_state kept", {128'b0, st1}, {128'b0, S5});
    hold1 = 0; tick();
    start1 = 1; num1 = 9; tick(); start1 = 0; num1 = 5;
    tick();
    chk("hold issued before last", {224'b0, iss1}, 256'd4);
    tick();
    chk("hold issued final", {224'b0, iss1}, 256'd5);
    chk("hold busy in drain", {255'b0, busy1}, 256'd1);
    wait_done(1, 60);
    tick();

    // Reset mid-DRAIN, then a clean rerun
    num1 = 3; sseed1 = S3; kseed1 = K5;
    start1 = 1; tick(); start1 = 0;
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_zero1("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    q1.push_back(mk(3, 3, model_sig(S3, 3)));
    start1 = 1; tick(); start1 = 0;
    wait_done(1, 60);
    tick();

    // Zero seeds are substituted
    num1 = 2; sseed1 = '0; kseed1 = '0;
    q1.push_back(mk(2, 2, model_sig('0, 2)));
    start1 = 1; tick(); start1 = 0;
    tick(); tick();
    chk("zseed aes_state", {128'b0, st1}, {128'b0, ZSD});
    chk("zseed aes_key", {128'b0, key1}, {128'b0, ZSK[127:0]});
    wait_done(1, 60);
    tick();

    // 256-bit key, LATENCY 29, zero seeds
    num2 = 3; sseed2 = '0; kseed2 = '0;
    q2.push_back(mk(3, 3, model_sig('0, 3)));
    start2 = 1; tick(); start2 = 0;
    tick(); tick();
    chk("k256 aes_state", {128'b0, st2}, {128'b0, ZSD});
    chk("k256 aes_key", key2, ZSK);
    repeat (LAT2 - 1) tick();
    chk("k256 retire early", {224'b0, ret2}, 256'd0);
    tick();
    chk("k256 retire on time", {224'b0, ret2}, 256'd1);
    wait_done(2, 20);
    repeat (3) tick();

    chk("dut1 scoreboard drained", 256'(q1.size()), 256'd0);
    chk("dut2 scoreboard drained", 256'(q2.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
